// File: rtl/booth_r8_decode.sv
// Radix-8 Booth digit decoder: folds one group of s/d/t/q/n selects per cycle back into the operand.
// Optional legality checking (err output) is enabled with `define BOOTH_DEC_CHECK_EN.
module booth_r8_decode #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned GROUPS = (WIDTH >> 2) + 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [GROUPS-1:0] s,
    input  logic [GROUPS-1:0] d,
    input  logic [GROUPS-1:0] t,
    input  logic [GROUPS-1:0] q,
    input  logic [GROUPS-1:0] n,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  mx_dec,
    output logic              err
);

    localparam int unsigned AW = WIDTH + 4;
    localparam int unsigned IW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(GROUPS - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                 state_q, state_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [GROUPS-1:0]      s_q, d_q, t_q, q_q, n_q;
    logic                   capture;

    logic                   bit_s, bit_d, bit_t, bit_q, bit_n;
    logic [2:0]             mag;
    logic signed [AW-1:0]   mag_ext, digit, acc_fold;

`ifdef BOOTH_DEC_CHECK_EN
    logic multi;
    logic out_of_range;
    logic err_q, err_d;
`endif

    // Digit of the group currently addressed by idx_q, and the folded accumulator.
    always_comb begin
        bit_s = s_q[idx_q];
        bit_d = d_q[idx_q];
        bit_t = t_q[idx_q];
        bit_q = q_q[idx_q];
        bit_n = n_q[idx_q];
        mag   = 3'd0;
`ifdef BOOTH_DEC_CHECK_EN
        multi = (bit_s & bit_d) | (bit_s & bit_t) | (bit_s & bit_q) |
                (bit_d & bit_t) | (bit_d & bit_q) | (bit_t & bit_q);
        // Illegal multi-select groups contribute nothing; the error flag records them.
        if (!multi) begin
            mag = {bit_q, bit_d | bit_t, bit_s | bit_t};
        end
`else
        if (bit_q) begin
            mag = 3'd4;
        end else if (bit_t) begin
            mag = 3'd3;
        end else if (bit_d) begin
            mag = 3'd2;
        end else if (bit_s) begin
            mag = 3'd1;
        end
`endif
        mag_ext  = {{(AW-3){1'b0}}, mag};
        digit    = bit_n ? -mag_ext : mag_ext;
        acc_fold = (acc_q <<< 3) + digit;
`ifdef BOOTH_DEC_CHECK_EN
        // Negative or >= 2^WIDTH both show up as nonzero bits above the operand width.
        out_of_range = |acc_fold[AW-1:WIDTH];
`endif
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        capture   = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mx_dec    = '0;
`ifdef BOOTH_DEC_CHECK_EN
        err_d     = err_q;
        err       = 1'b0;
`else
        err       = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture = 1'b1;
                    acc_d   = '0;
                    idx_d   = IDX_TOP;
`ifdef BOOTH_DEC_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = StBusy;
                end
            end
            StBusy: begin
                acc_d = acc_fold;
`ifdef BOOTH_DEC_CHECK_EN
                err_d = err_q | multi;
`endif
                if (idx_q == '0) begin
                    idx_d   = IDX_TOP;
                    state_d = StDone;
`ifdef BOOTH_DEC_CHECK_EN
                    err_d   = err_q | multi | out_of_range;
`endif
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                mx_dec    = acc_q[WIDTH-1:0];
`ifdef BOOTH_DEC_CHECK_EN
                err       = err_q;
`endif
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            acc_q   <= '0;
            idx_q   <= IDX_TOP;
            s_q     <= '0;
            d_q     <= '0;
            t_q     <= '0;
            q_q     <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            if (capture) begin
                s_q <= s;
                d_q <= d;
                t_q <= t;
                q_q <= q;
                n_q <= n;
            end
        end
    end

`ifdef BOOTH_DEC_CHECK_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_booth_r8_decode.sv
// Scoreboard bench for booth_r8_decode: driver pushes expected results, a monitor pops on handshake.
module tb_booth_r8_decode;

    localparam int W = 32;
    localparam int G = 11;
`ifdef BOOTH_DEC_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic         in_valid, in_ready, out_valid, out_ready, err;
    logic [G-1:0] s, d, t, q, n;
    logic [W-1:0] mx_dec;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [W-1:0] mx;
        logic         e;
    } exp_t;
    exp_t sb_q[$];

    always #5 CLK = ~CLK;

    booth_r8_decode #(.WIDTH(W), .GROUPS(G)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .d         (d),
        .t         (t),
        .q         (q),
        .n         (n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mx_dec    (mx_dec),
        .err       (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: result handshake happens at the next rising edge.
    always @(negedge CLK) begin
        exp_t e;
        if (RST === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got mx_dec 0x%0h, expected no result", mx_dec);
            end else begin
                e = sb_q.pop_front();
                check("mx_dec", 64'(mx_dec), 64'(e.mx));
                check("err", 64'(err), 64'(e.e));
            end
        end
    end

    task automatic send(input logic [G-1:0] vs, vd, vt, vq, vn);
        int w;
        @(posedge CLK);
        #1;
        s = vs; d = vd; t = vt; q = vq; n = vn;
        in_valid = 1'b1;
        w = 0;
        @(negedge CLK);
        while (!in_ready && w < 50) begin
            @(negedge CLK);
            w++;
        end
        check("accept_wait", 64'(w < 50), 64'd1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    // Called just after the acceptance edge; returns edges until out_valid is seen.
    task automatic wait_out(output int cyc);
        cyc = 0;
        @(negedge CLK);
        while (!out_valid && cyc < 40) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic run_vec(input string name, input logic [G-1:0] vs, vd, vt, vq, vn,
                           input logic [W-1:0] emx, input logic eerr);
        int cyc;
        exp_t e;
        e.mx = emx;
        e.e  = eerr;
        sb_q.push_back(e);
        send(vs, vd, vt, vq, vn);
        wait_out(cyc);
        check({"latency_", name}, 64'(cyc), 64'(G));
        @(negedge CLK);
        check({"ready_after_", name}, 64'(in_ready), 64'd1);
        check({"valid_drop_", name}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int   cyc;
        exp_t e;
        RST = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        s = '0; d = '0; t = '0; q = '0; n = '0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_mx_dec", 64'(mx_dec), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        run_vec("zero",    11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 32'h0000_0000, 1'b0);
        run_vec("seven",   11'h003, 11'h000, 11'h000, 11'h000, 11'h001, 32'h0000_0007, 1'b0);
        run_vec("allones", 11'h001, 11'h000, 11'h000, 11'h400, 11'h001, 32'hFFFF_FFFF, 1'b0);
        run_vec("three",   11'h000, 11'h000, 11'h001, 11'h000, 11'h000, 32'h0000_0003, 1'b0);
        run_vec("four",    11'h002, 11'h000, 11'h000, 11'h001, 11'h001, 32'h0000_0004, 1'b0);
        run_vec("t5",      11'h000, 11'h000, 11'h020, 11'h000, 11'h000, 32'h0001_8000, 1'b0);
        run_vec("negzero", 11'h000, 11'h000, 11'h000, 11'h000, 11'h7FF, 32'h0000_0000, 1'b0);
        // 4*8 - 2*64 = -96
        run_vec("negative", 11'h000, 11'h004, 11'h000, 11'h002, 11'h004, 32'hFFFF_FFA0, CHK);
        run_vec("multi",   11'h008, 11'h008, 11'h000, 11'h000, 11'h000,
                CHK ? 32'h0000_0000 : 32'h0000_0400, CHK);
        run_vec("over",    11'h000, 11'h000, 11'h000, 11'h400, 11'h000, 32'h0000_0000, CHK);

        // Backpressure: result 24 held for 5 cycles while a stray in_valid is offered.
        out_ready = 1'b0;
        e.mx = 32'h0000_0018; e.e = 1'b0;
        sb_q.push_back(e);
        send(11'h000, 11'h000, 11'h002, 11'h000, 11'h000);
        wait_out(cyc);
        check("bp_latency", 64'(cyc), 64'(G));
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            in_valid = 1'b1;
            s = 11'h7FF; d = 11'h000; t = 11'h000; q = 11'h000; n = 11'h000;
            @(negedge CLK);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_mx_dec", 64'(mx_dec), 64'h18);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge CLK);
        #1;
        out_ready = 1'b1;
        s = 11'h001; n = 11'h000;
        e.mx = 32'h0000_0001; e.e = 1'b0;
        sb_q.push_back(e);
        @(negedge CLK);
        check("bp_hs_pending_ready", 64'(in_ready), 64'd0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("bp_hs_ready", 64'(in_ready), 64'd1);
        check("bp_hs_valid", 64'(out_valid), 64'd0);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        @(negedge CLK);
        check("bp_next_accepted", 64'(in_ready), 64'd0);
        wait_out(cyc);
        check("bp_next_latency", 64'(cyc), 64'(G - 1));
        @(negedge CLK);

        // Reset during BUSY at fold 5: the operation is discarded.
        send(11'h0FF, 11'h000, 11'h000, 11'h000, 11'h000);
        repeat (5) @(negedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("abort_busy_in_ready", 64'(in_ready), 64'd1);
        check("abort_busy_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy_mx_dec", 64'(mx_dec), 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        run_vec("post_rst", 11'h001, 11'h000, 11'h000, 11'h400, 11'h001, 32'hFFFF_FFFF, 1'b0);

        // Reset while a result is waiting in DONE.
        out_ready = 1'b0;
        send(11'h003, 11'h000, 11'h000, 11'h000, 11'h001);
        wait_out(cyc);
        check("done_hold_valid", 64'(out_valid), 64'd1);
        #2;
        RST = 1'b0;
        #1;
        check("abort_done_out_valid", 64'(out_valid), 64'd0);
        check("abort_done_mx_dec", 64'(mx_dec), 64'd0);
        check("abort_done_in_ready", 64'(in_ready), 64'd1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        out_ready = 1'b1;
        run_vec("post_rst2", 11'h003, 11'h000, 11'h000, 11'h000, 11'h001, 32'h0000_0007, 1'b0);

        repeat (3) @(negedge CLK);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected finish before 200000");
        $fatal(1);
    end

endmodule
